// File: rtl/imem_loader_pkg.sv
// Shared state codes and timer helpers for the instruction-SRAM boot loader.
package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_STROBE  = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int TMR_W = 8;

    // A dwell of N cycles loads N-1; the state exits on the cycle the count reads zero.
    function automatic logic [TMR_W-1:0] dwell(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/imem_loader_sram_wr_timer.sv
// Loadable down-counter with a zero flag; paces SETUP, STROBE and DONE dwell times.
module imem_loader_sram_wr_timer
    import imem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot/debug loader: packs a byte stream into 32-bit words and writes them into
// the instruction SRAM with timed WE# strobes while holding the core in reset.
//
// state   | meaning
// IDLE    | waiting for start or go
// COLLECT | accepting 4 bytes of the next word
// SETUP   | addr/data stable, WE# high
// STROBE  | WE# low
// HOLD    | WE# high, word committed, pointers advanced
// DONE    | core still in reset for the release delay
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          WSETUP  = 1,
    parameter int          WPULSE  = 2,
    parameter int          RELEASE = 4,
    parameter logic [31:0] BOOT_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              go,
    input  logic              abort,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              cpu_rst,
    output logic [31:0]       rst_addr,
    output logic              debug_imem_oe,
    output logic              debug_imem_we,
    output logic [31:0]       debug_imem_addr,
    output logic [31:0]       debug_imem_data,
    output logic              busy,
    output logic [31:0]       checksum,
    output logic              err_wrap
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              err_wrap_q, err_wrap_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              we_q, we_d;
    logic              abort_seen_q, abort_seen_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              abort_any;

    imem_loader_sram_wr_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign abort_any = abort | abort_seen_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        data_d       = data_q;
        byte_idx_d   = byte_idx_q;
        checksum_d   = checksum_q;
        err_wrap_d   = err_wrap_q;
        cpu_rst_d    = cpu_rst_q;
        abort_seen_d = abort_seen_q | ((state_q != ST_IDLE) & abort);
        tmr_load     = 1'b0;
        tmr_val      = dwell(RELEASE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = load_base;
                    count_d      = load_len;
                    byte_idx_d   = 2'd0;
                    checksum_d   = '0;
                    err_wrap_d   = 1'b0;
                    cpu_rst_d    = 1'b1;
                    abort_seen_d = 1'b0;
                    if (load_len == '0) begin
                        state_d  = ST_DONE;
                        tmr_load = 1'b1;
                    end else begin
                        state_d  = ST_COLLECT;
                    end
                end else if (go) begin
                    state_d  = ST_DONE;
                    tmr_load = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (abort_any) begin
                    // partial word is simply abandoned
                    state_d  = ST_DONE;
                    tmr_load = 1'b1;
                end else if (in_valid) begin
                    data_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = dwell(WSETUP);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = dwell(WPULSE);
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                checksum_d = checksum_q + data_q;
                addr_d     = addr_q + ADDR_W'(1);
                count_d    = count_q - ADDR_W'(1);
                if (&addr_q) begin
                    err_wrap_d = 1'b1;
                end
                if ((count_q == ADDR_W'(1)) || abort_any) begin
                    state_d  = ST_DONE;
                    tmr_load = 1'b1;
                end else begin
                    state_d  = ST_COLLECT;
                end
            end
            ST_DONE: begin
                if (tmr_zero) begin
                    state_d   = ST_IDLE;
                    cpu_rst_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // WE# is registered so the SRAM sees a glitch-free strobe
        we_d = (state_d != ST_STROBE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            data_q       <= '0;
            byte_idx_q   <= 2'd0;
            checksum_q   <= '0;
            err_wrap_q   <= 1'b0;
            cpu_rst_q    <= 1'b1;
            we_q         <= 1'b1;
            abort_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            byte_idx_q   <= byte_idx_d;
            checksum_q   <= checksum_d;
            err_wrap_q   <= err_wrap_d;
            cpu_rst_q    <= cpu_rst_d;
            we_q         <= we_d;
            abort_seen_q <= abort_seen_d;
        end
    end

    assign in_ready        = (state_q == ST_COLLECT) & ~abort_seen_q;
    assign cpu_rst         = cpu_rst_q;
    assign rst_addr        = BOOT_PC;
    assign debug_imem_oe   = cpu_rst_q;
    assign debug_imem_we   = we_q;
    assign debug_imem_addr = 32'(addr_q);
    assign debug_imem_data = data_q;
    assign busy            = (state_q != ST_IDLE);
    assign checksum        = checksum_q;
    assign err_wrap        = err_wrap_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads against a word-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] load_base = '0;
    logic [15:0] load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        cpu_rst;
    logic [31:0] rst_addr;
    logic        debug_imem_oe;
    logic        debug_imem_we;
    logic [31:0] debug_imem_addr;
    logic [31:0] debug_imem_data;
    logic        busy;
    logic [31:0] checksum;
    logic        err_wrap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .go              (go),
        .abort           (abort),
        .load_base       (load_base),
        .load_len        (load_len),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .cpu_rst         (cpu_rst),
        .rst_addr        (rst_addr),
        .debug_imem_oe   (debug_imem_oe),
        .debug_imem_we   (debug_imem_we),
        .debug_imem_addr (debug_imem_addr),
        .debug_imem_data (debug_imem_data),
        .busy            (busy),
        .checksum        (checksum),
        .err_wrap        (err_wrap)
    );

    // Bus monitor: records every completed WE# pulse as a write transaction.
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_width[$];
    bit          wr_stable[$];
    int          cyc = 0;
    int          last_rise = 0;
    int          fall_cyc = 0;
    int          rdy_cnt = 0;
    int          oe_bad = 0;
    int          low_cnt = 0;
    bit          stab = 1'b1;
    logic        prev_cpu = 1'b1;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            low_cnt  = 0;
            prev_cpu = 1'b1;
        end else begin
            if (in_ready) rdy_cnt++;
            if (cpu_rst && !debug_imem_oe) oe_bad++;
            if (!debug_imem_we) begin
                if (low_cnt == 0) stab = 1'b1;
                stab = stab && (debug_imem_addr == p_addr) && (debug_imem_data == p_data);
                low_cnt++;
            end else if (low_cnt > 0) begin
                stab = stab && (debug_imem_addr == p_addr) && (debug_imem_data == p_data);
                wr_addr.push_back(debug_imem_addr[15:0]);
                wr_data.push_back(debug_imem_data);
                wr_width.push_back(low_cnt);
                wr_stable.push_back(stab);
                last_rise = cyc;
                low_cnt   = 0;
            end
            if (prev_cpu && !cpu_rst) fall_cyc = cyc;
            prev_cpu = cpu_rst;
        end
        p_addr = debug_imem_addr;
        p_data = debug_imem_data;
    end

    logic [7:0] byte_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // mode 0: plain load, 1: abort while WE# is low, 2: abort after two bytes of word 0
    task automatic run(input logic [15:0] base, input int len, input bit thr,
                       input bit poke, input int mode);
        logic [31:0] exp_w[$];
        logic [31:0] sum;
        int          n_exp;
        int          w0, oe0, rdy0, idx, budget;
        bit          aborted, snap_pending;

        n_exp = (mode == 0) ? len : ((mode == 1) ? 1 : 0);
        sum   = '0;
        for (int i = 0; i < n_exp; i++) begin
            exp_w.push_back({byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]});
            sum = sum + exp_w[i];
        end

        w0  = wr_addr.size();
        oe0 = oe_bad;
        rdy0 = 0;
        aborted = 1'b0;
        snap_pending = 1'b0;

        @(negedge clk);
        load_base = base;
        load_len  = 16'(len);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        load_base = 16'($urandom);
        load_len  = 16'($urandom);

        idx = 0;
        budget = 0;
        while (busy && budget < 3000) begin
            start = poke && (budget == 6);
            if (mode == 1 && !aborted && !debug_imem_we) begin
                abort = 1'b1;
                aborted = 1'b1;
                snap_pending = 1'b1;
            end else if (mode == 2 && !aborted && idx == 2) begin
                abort = 1'b1;
                aborted = 1'b1;
                snap_pending = 1'b1;
            end else begin
                abort = 1'b0;
                if (snap_pending) begin
                    #1;
                    rdy0 = rdy_cnt;
                    snap_pending = 1'b0;
                end
            end
            in_valid = aborted ? 1'b1 : ((idx < byte_q.size()) && (!thr || cyc[0]));
            in_data  = (in_valid && idx < byte_q.size()) ? byte_q[idx] : 8'($urandom);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        #1;

        chk("load_timeout", 32'(budget < 3000), 32'd1);
        chk("write_count", 32'(wr_addr.size() - w0), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (w0 + i < wr_addr.size()) begin
                chk("write_addr", 32'(wr_addr[w0+i]), 32'(16'(base + 16'(i))));
                chk("write_data", wr_data[w0+i], exp_w[i]);
                chk("we_width", 32'(wr_width[w0+i]), 32'd2);
                chk("bus_stable", 32'(wr_stable[w0+i]), 32'd1);
            end
        end
        chk("checksum", checksum, sum);
        chk("err_wrap", 32'(err_wrap), 32'((32'(base) + 32'(n_exp)) > 32'hFFFF));
        chk("cpu_rst_released", 32'(cpu_rst), 32'd0);
        chk("oe_while_reset", 32'(oe_bad - oe0), 32'd0);
        if (n_exp > 0) chk("release_delay", 32'(fall_cyc - last_rise), 32'd5);
        if (mode != 0) chk("no_ready_after_abort", 32'(rdy_cnt - rdy0), 32'd0);
    endtask

    initial begin
        int budget;
        int w_before;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_we", 32'(debug_imem_we), 32'd1);
        chk("rst_oe", 32'(debug_imem_oe), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_addr_bus", debug_imem_addr, 32'd0);
        chk("rst_data_bus", debug_imem_data, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_err_wrap", 32'(err_wrap), 32'd0);
        chk("rst_addr_pc", rst_addr, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // go alone releases the core after the release delay
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        chk("go_cpu_rst_held", 32'(cpu_rst), 32'd1);
        chk("go_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("go_cpu_rst_released", 32'(cpu_rst), 32'd0);
        chk("go_idle", 32'(busy), 32'd0);

        byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run(16'h0010, 2, 1'b0, 1'b0, 0);
        chk("directed_checksum", checksum, 32'hF0E21567);

        run(16'h0010, 2, 1'b1, 1'b1, 0);
        chk("throttled_checksum", checksum, 32'hF0E21567);

        fill_random(8);
        run(16'hFFFF, 2, 1'b0, 1'b0, 0);
        chk("wrap_flag", 32'(err_wrap), 32'd1);

        fill_random(12);
        run(16'($urandom), 3, 1'b0, 1'b0, 1);

        fill_random(8);
        run(16'h0200, 2, 1'b1, 1'b0, 2);

        byte_q.delete();
        run(16'h0300, 0, 1'b0, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            int len;
            logic [15:0] base;
            len  = int'($urandom_range(1, 4));
            base = (k == 2) ? 16'hFFFE : 16'($urandom);
            fill_random(4 * len);
            run(base, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        // reset during a strobe forces WE# high at once and discards the word
        fill_random(8);
        w_before = wr_addr.size();
        @(negedge clk);
        load_base = 16'h0400;
        load_len  = 16'd2;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        budget   = 0;
        while (debug_imem_we && budget < 200) begin
            in_data = byte_q[budget % 8];
            @(negedge clk);
            budget++;
        end
        chk("strobe_reached", 32'(budget < 200), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(debug_imem_we), 32'd1);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_write", 32'(wr_addr.size() - w_before), 32'd0);
        chk("mid_rst_stays_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
